mem_wb_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU; consumes the ALU result, the second register operand and the control bits produced alongside them.
- Holds the EX/MEM pipeline register, a word-addressed data memory and the MEM/WB pipeline register.
- Produces the write-back triple (Regwrite, WriteReg, WriteData) that drives the register bank write port.
- Turns the current ALU-result-straight-to-register-bank path into a full load/store pipeline.

---
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: EX/MEM register, word-addressed data memory with
// asynchronous read, and MEM/WB register driving the register-bank write port.
module mem_wb_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    output logic [4:0]  mem_reg,
    output logic        mem_regwrite,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_writereg,
    output logic [31:0] wb_writedata,
    output logic        wb_error
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_alu_q, ex_alu_d;
    logic [31:0] ex_store_q, ex_store_d;
    logic [4:0]  ex_wreg_q, ex_wreg_d;
    logic        ex_regwrite_q, ex_regwrite_d;
    logic        ex_memread_q, ex_memread_d;
    logic        ex_memwrite_q, ex_memwrite_d;
    logic        ex_memtoreg_q, ex_memtoreg_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_writereg_q, wb_writereg_d;
    logic [31:0] wb_writedata_q, wb_writedata_d;
    logic        wb_error_q, wb_error_d;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 fault;
    logic                 store_en;
    logic [31:0]          load_data;

    // Data fields are captured every cycle; a bubble only clears valid and control.
    always_comb begin
        ex_valid_d    = in_valid;
        ex_alu_d      = alu_result;
        ex_store_d    = store_data;
        ex_wreg_d     = write_reg;
        ex_regwrite_d = reg_write;
        ex_memread_d  = mem_read;
        ex_memwrite_d = mem_write;
        ex_memtoreg_d = mem_to_reg;
        if (!in_valid) begin
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
            ex_memtoreg_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_alu_q      <= '0;
            ex_store_q    <= '0;
            ex_wreg_q     <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_alu_q      <= ex_alu_d;
            ex_store_q    <= ex_store_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
        end
    end

    assign word_idx = ex_alu_q[ADDR_BITS+1:2];
    assign fault    = ex_valid_q & (ex_memread_q | ex_memwrite_q) &
                      ((ex_alu_q[1:0] != 2'b00) | (ex_memread_q & ex_memwrite_q));
    assign store_en = ex_valid_q & ex_memwrite_q & ~fault;

    // A store still in EX/MEM when reset hits is dropped, so gate with reset.
    always_ff @(posedge clk) begin
        if (!reset && store_en) begin
            mem_q[word_idx] <= ex_store_q;
        end
    end

    always_comb begin
        load_data = '0;
        if (ex_valid_q && ex_memread_q && !fault) begin
            load_data = mem_q[word_idx];
        end
        wb_valid_d     = ex_valid_q;
        wb_regwrite_d  = ex_valid_q & ex_regwrite_q & (ex_wreg_q != 5'd0) & ~fault;
        wb_writereg_d  = ex_wreg_q;
        wb_writedata_d = ex_memtoreg_q ? load_data : ex_alu_q;
        wb_error_d     = fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_writereg_q  <= '0;
            wb_writedata_q <= '0;
            wb_error_q     <= 1'b0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_writereg_q  <= wb_writereg_d;
            wb_writedata_q <= wb_writedata_d;
            wb_error_q     <= wb_error_d;
        end
    end

    assign mem_reg      = ex_wreg_q;
    assign mem_regwrite = ex_valid_q & ex_regwrite_q & (ex_wreg_q != 5'd0);
    assign wb_valid     = wb_valid_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_writereg  = wb_writereg_q;
    assign wb_writedata = wb_writedata_q;
    assign wb_error     = wb_error_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed load/store/fault/reset scenarios followed by
// random traffic, all checked against an in-order instruction-level model.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  mem_reg;
    logic        mem_regwrite;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_writedata;
    logic        wb_error;

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .mem_reg(mem_reg), .mem_regwrite(mem_regwrite),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
        .wb_writedata(wb_writedata), .wb_error(wb_error)
    );

    typedef struct {
        bit          valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wr;
        bit          rw, mr, mw, m2r;
    } txn_t;

    typedef struct {
        bit          valid, regwrite, error;
        logic [4:0]  writereg;
        logic [31:0] writedata;
    } res_t;

    logic [31:0] model_mem [256];
    txn_t        inflight [$];
    res_t        exp_wb;
    bit          exp_zero;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit v, input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] w, input bit rw, input bit mr,
                                input bit mw, input bit m2r);
        txn_t t;
        t.valid = v; t.alu = a; t.sd = d; t.wr = w;
        t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r;
        return t;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r.valid = 0; r.regwrite = 0; r.error = 0; r.writereg = '0; r.writedata = '0;
        return r;
    endfunction

    // Executes one instruction against the model memory and returns its write-back.
    task automatic execute(input txn_t t, output res_t r);
        int          idx;
        bit          flt;
        logic [31:0] ld;
        idx = int'((t.alu >> 2) % 256);
        flt = t.valid && (t.mr || t.mw) && (((t.alu % 4) != 0) || (t.mr && t.mw));
        ld  = 32'd0;
        if (t.valid && t.mr && !flt) ld = model_mem[idx];
        if (t.valid && t.mw && !flt) model_mem[idx] = t.sd;
        r.valid     = t.valid;
        r.regwrite  = t.valid && t.rw && (t.wr != 0) && !flt;
        r.error     = flt;
        r.writereg  = t.wr;
        r.writedata = t.m2r ? ld : t.alu;
    endtask

    task automatic cycle(input txn_t t, input bit rst);
        txn_t head;
        reset      = rst;
        in_valid   = t.valid;
        alu_result = t.alu;
        store_data = t.sd;
        write_reg  = t.wr;
        reg_write  = t.rw;
        mem_read   = t.mr;
        mem_write  = t.mw;
        mem_to_reg = t.m2r;
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            exp_zero = 1;
            exp_wb   = zero_res();
        end else begin
            exp_zero = 0;
            if (inflight.size() > 0) execute(inflight.pop_front(), exp_wb);
            else exp_wb = zero_res();
            inflight.push_back(t);
        end
        @(negedge clk);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wb.valid});
        chk("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, exp_wb.regwrite});
        chk("wb_error", {31'd0, wb_error}, {31'd0, exp_wb.error});
        if (exp_zero || exp_wb.valid) begin
            chk("wb_writereg", {27'd0, wb_writereg}, {27'd0, exp_wb.writereg});
            chk("wb_writedata", wb_writedata, exp_wb.writedata);
        end
        if (exp_zero) begin
            chk("mem_reg_rst", {27'd0, mem_reg}, 32'd0);
            chk("mem_regwrite_rst", {31'd0, mem_regwrite}, 32'd0);
        end else begin
            head = inflight[0];
            chk("mem_regwrite", {31'd0, mem_regwrite},
                {31'd0, head.valid && head.rw && (head.wr != 0)});
            if (head.valid) chk("mem_reg", {27'd0, mem_reg}, {27'd0, head.wr});
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t        t;
        logic [31:0] a;
        int          kind;
        a = $urandom;
        if ($urandom % 8 != 0) a[1:0] = 2'b00;
        kind = int'($urandom % 4);
        t = mk(($urandom % 5) != 0, a, $urandom, 5'($urandom), 1'($urandom), 0, 0, 0);
        case (kind)
            0: t.alu = $urandom;
            1: begin t.mr = 1; t.m2r = 1; end
            2: t.mw = 1;
            default: begin t.mr = 1'($urandom); t.mw = 1'($urandom); t.m2r = t.mr; end
        endcase
        return t;
    endfunction

    txn_t        idle;
    logic [31:0] pre;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(idle, 1);
        repeat (3) cycle(idle, 0);

        for (int i = 0; i < 256; i++) cycle(mk(1, 32'(i * 4), $urandom, 0, 0, 0, 1, 0), 0);

        cycle(mk(1, 32'h25, 0, 8, 1, 0, 0, 0), 0);
        chk("alu_mem_reg", {27'd0, mem_reg}, 32'd8);
        chk("alu_mem_regwrite", {31'd0, mem_regwrite}, 32'd1);
        cycle(idle, 0);
        chk("alu_wb_data", wb_writedata, 32'h25);
        chk("alu_wb_reg", {27'd0, wb_writereg}, 32'd8);

        cycle(mk(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 0), 0);
        cycle(mk(1, 32'h10, 0, 9, 1, 1, 0, 1), 0);
        cycle(idle, 0);
        chk("st_ld_data", wb_writedata, 32'hDEADBEEF);
        chk("st_ld_reg", {27'd0, wb_writereg}, 32'd9);
        chk("st_ld_we", {31'd0, wb_regwrite}, 32'd1);

        cycle(mk(1, 32'h404, 32'h1234, 0, 0, 0, 1, 0), 0);
        cycle(mk(1, 32'h004, 0, 3, 1, 1, 0, 1), 0);
        cycle(idle, 0);
        chk("alias_data", wb_writedata, 32'h1234);

        pre = model_mem[4];
        cycle(mk(1, 32'h12, 32'hCAFEF00D, 4, 1, 0, 1, 0), 0);
        cycle(idle, 0);
        chk("misal_err", {31'd0, wb_error}, 32'd1);
        chk("misal_we", {31'd0, wb_regwrite}, 32'd0);
        cycle(mk(1, 32'h10, 0, 5, 1, 1, 0, 1), 0);
        cycle(idle, 0);
        chk("misal_prior", wb_writedata, pre);

        cycle(mk(1, 32'h20, 32'h77, 6, 1, 1, 1, 1), 0);
        cycle(idle, 0);
        chk("rdwr_err", {31'd0, wb_error}, 32'd1);
        chk("rdwr_data", wb_writedata, 32'd0);

        pre = model_mem[8];
        cycle(mk(1, 32'h20, 32'h5A5A5A5A, 0, 0, 0, 1, 0), 0);
        cycle(idle, 1);
        cycle(mk(1, 32'h20, 0, 7, 1, 1, 0, 1), 0);
        cycle(idle, 0);
        chk("rst_drop_store", wb_writedata, pre);

        cycle(mk(1, 32'h55, 0, 0, 1, 0, 0, 0), 0);
        chk("r0_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);
        cycle(idle, 0);
        chk("r0_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);

        for (int i = 0; i < 3000; i++) cycle(rand_txn(), ($urandom % 150) == 0);
        cycle(idle, 0);
        cycle(idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
